// File: rtl/vrf_rd_seq.sv
// -----------------------------------------------------------------------------
// vrf_rd_seq
//   Read-port sequencer for one VRF read port. It accepts a vector operand
//   request (start address + element count) and issues one read per cycle
//   with consecutive, wrapping addresses. It collects the read data after the
//   fixed read latency into a small credit-protected FIFO. The FIFO then
//   streams the elements to the lane ALU over valid/ready, with last on the
//   final element.
//
// Parameters
//   MEM_DEPTH   VRF depth per lane (power of two); address width = clog2.
//   MEM_WIDTH   element width.
//   RD_LATENCY  cycles from ren_o to valid vrf_dout_i (1..4).
//   CNT_W       element count width.
//   BUF_DEPTH   output FIFO entries (>= RD_LATENCY+1).
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   start_i             request strobe, taken only while ready_o=1
//   base_addr_i, len_i  first VRF address and element count of the request
//   abort_i             cancel the running request (ignored when idle)
//   ready_o             sequencer idle, start_i will be accepted
//   raddr_o, ren_o      VRF read address / read enable
//   oreg_en_o           VRF output-register enable
//   vrf_dout_i          VRF read data
//   data_o, valid_o     element stream to the consumer
//   last_o              final element of the request
//   data_ready_i        consumer ready
//   done_o              one-cycle pulse once the request is fully delivered
// -----------------------------------------------------------------------------
module vrf_rd_seq #(
    parameter int MEM_DEPTH  = 512,
    parameter int MEM_WIDTH  = 32,
    parameter int RD_LATENCY = 2,
    parameter int CNT_W      = 10,
    parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] base_addr_i,
    input  logic [CNT_W-1:0]             len_i,
    input  logic                         abort_i,
    output logic                         ready_o,
    output logic [$clog2(MEM_DEPTH)-1:0] raddr_o,
    output logic                         ren_o,
    output logic                         oreg_en_o,
    input  logic [MEM_WIDTH-1:0]         vrf_dout_i,
    output logic [MEM_WIDTH-1:0]         data_o,
    output logic                         valid_o,
    output logic                         last_o,
    input  logic                         data_ready_i,
    output logic                         done_o
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int FW = $clog2(RD_LATENCY + 1);

    localparam logic [OW-1:0] OCC_MAX    = OW'(BUF_DEPTH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(RD_LATENCY - 1);
    localparam logic [BW-1:0] PTR_LAST   = BW'(BUF_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // FIFO pointers wrap explicitly so BUF_DEPTH need not be a power of two.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + BW'(1);
    endfunction

    // Control state
    logic [1:0]            r_state;
    logic                  r_ready;
    logic                  r_ren;
    logic [AW-1:0]         r_raddr;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_dlvd;
    logic [OW-1:0]         r_occ;
    logic                  r_done;
    logic [FW-1:0]         r_flush_cnt;
    logic [RD_LATENCY-1:0] r_vld_p;

    // Output FIFO
    logic [MEM_WIDTH-1:0]  r_mem [BUF_DEPTH];
    logic [BW-1:0]         r_wr_ptr;
    logic [BW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_cnt;

    logic                  w_active;
    logic                  w_abort;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_last;
    logic                  w_last_hs;
    logic [CNT_W-1:0]      w_iss_nxt;
    logic [OW-1:0]         w_occ_nxt;
    logic                  w_ren_nxt;

    assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_abort   = w_active && abort_i;
    assign w_valid   = (r_cnt != '0);
    assign w_pop     = w_valid && data_ready_i;
    // Returns are dropped during FLUSH and in the cycle the abort is taken.
    assign w_push    = r_vld_p[RD_LATENCY-1] && w_active && !abort_i;
    assign w_last    = w_valid && (r_dlvd == r_len - CNT_W'(1));
    assign w_last_hs = w_pop && w_last;

    // r_occ counts reads issued before this cycle that are not yet consumed,
    // i.e. in flight in the VRF or sitting in the FIFO. Because ren_o is
    // registered, the decision for the next cycle folds in this cycle's
    // issue and pop. That way ren_o can never request more than BUF_DEPTH
    // outstanding elements.
    assign w_iss_nxt = r_issued + CNT_W'(r_ren);
    assign w_occ_nxt = r_occ + OW'(r_ren) - OW'(w_pop);
    assign w_ren_nxt = (w_iss_nxt < r_len) && (w_occ_nxt < OCC_MAX);

    // ---- stage: request control / read issue ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_ren       <= 1'b0;
            r_raddr     <= '0;
            r_issued    <= '0;
            r_len       <= '0;
            r_dlvd      <= '0;
            r_occ       <= '0;
            r_done      <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_state  <= ST_ISSUE;
                            r_ready  <= 1'b0;
                            r_ren    <= 1'b1;
                            r_raddr  <= base_addr_i;
                            r_issued <= '0;
                            r_len    <= len_i;
                            r_dlvd   <= '0;
                            r_occ    <= '0;
                        end else begin
                            // Empty request completes immediately without touching the VRF.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (abort_i) begin
                        // Abort beats a coincident final handshake: no done pulse.
                        r_state     <= ST_FLUSH;
                        r_ren       <= 1'b0;
                        r_occ       <= '0;
                        r_flush_cnt <= FLUSH_LAST;
                    end else begin
                        r_issued <= w_iss_nxt;
                        r_occ    <= w_occ_nxt;
                        r_raddr  <= r_raddr + AW'(r_ren);
                        if (w_pop) begin
                            r_dlvd <= r_dlvd + CNT_W'(1);
                        end
                        if (w_last_hs) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_ren   <= 1'b0;
                        end else if (r_state == ST_ISSUE) begin
                            r_ren <= w_ren_nxt;
                            if (w_iss_nxt == r_len) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Wait out the reads still in the VRF pipeline before accepting new work.
                    if (r_flush_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_ren   <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage: VRF read latency (valid shift register) ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= r_ren;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    // The VRF output register must capture one cycle after the read strobe;
    // with single-cycle latency there is no output register to time.
    generate
        if (RD_LATENCY >= 2) begin : g_oreg_timed
            assign oreg_en_o = r_vld_p[RD_LATENCY-2];
        end else begin : g_oreg_const
            assign oreg_en_o = 1'b1;
        end
    endgenerate

    // ---- stage: read-data capture into output FIFO ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= vrf_dout_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt <= r_cnt + OW'(w_push) - OW'(w_pop);
        end
    end

    // ---- stage: stream output ----
    assign data_o  = r_mem[r_rd_ptr];
    assign valid_o = w_valid;
    assign last_o  = w_last;
    assign ready_o = r_ready;
    assign raddr_o = r_raddr;
    assign ren_o   = r_ren;
    assign done_o  = r_done;

endmodule

// File: tb/tb_vrf_rd_seq.sv
// -----------------------------------------------------------------------------
// tb_vrf_rd_seq
//   Self-checking bench for vrf_rd_seq. A BRAM-like VRF model returns
//   addr ^ 0xA5A5_0000 after RD_LATENCY cycles. A negedge monitor logs issues,
//   handshakes and done pulses per request. Those logs are compared against
//   the expected element sequence and timing of each request.
// -----------------------------------------------------------------------------
module tb_vrf_rd_seq;

    localparam int MEM_DEPTH  = 512;
    localparam int MEM_WIDTH  = 32;
    localparam int RD_LATENCY = 2;
    localparam int CNT_W      = 10;
    localparam int BUF_DEPTH  = RD_LATENCY + 2;
    localparam int AW         = $clog2(MEM_DEPTH);

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start_i = 1'b0;
    logic [AW-1:0]        base_addr_i = '0;
    logic [CNT_W-1:0]     len_i = '0;
    logic                 abort_i = 1'b0;
    logic                 data_ready_i = 1'b0;
    logic                 ready_o, ren_o, oreg_en_o, valid_o, last_o, done_o;
    logic [AW-1:0]        raddr_o;
    logic [MEM_WIDTH-1:0] vrf_dout_i, data_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vrf_rd_seq #(
        .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH), .RD_LATENCY(RD_LATENCY),
        .CNT_W(CNT_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .abort_i(abort_i), .ready_o(ready_o), .raddr_o(raddr_o),
        .ren_o(ren_o), .oreg_en_o(oreg_en_o), .vrf_dout_i(vrf_dout_i),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .data_ready_i(data_ready_i), .done_o(done_o)
    );

    function automatic logic [MEM_WIDTH-1:0] vrf_word(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ 32'(a);
    endfunction

    // VRF model: read strobe in cycle n -> data valid during cycle n+RD_LATENCY.
    logic [AW-1:0]         pa [RD_LATENCY];
    logic [RD_LATENCY-1:0] pv = '0;
    always @(posedge clk) begin
        pa[0] <= raddr_o;
        pv[0] <= ren_o;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign vrf_dout_i = pv[RD_LATENCY-1] ? vrf_word(pa[RD_LATENCY-1]) : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Per-request logs, cycle numbers relative to the start_i cycle.
    bit                   logging = 1'b0;
    int                   t0 = 0;
    int                   rel_m;
    int                   max_occ;
    logic                 prev_ren = 1'b0;
    int                   ren_cyc[$];
    logic [AW-1:0]        ren_addr[$];
    int                   hs_cyc[$];
    logic [MEM_WIDTH-1:0] hs_data[$];
    logic                 hs_last[$];
    int                   done_cyc[$];
    int                   valid_cyc[$];

    always @(negedge clk) begin
        if (logging) begin
            rel_m = cyc - t0;
            if (ren_o) begin
                ren_cyc.push_back(rel_m);
                ren_addr.push_back(raddr_o);
            end
            if (ren_cyc.size() - hs_cyc.size() > max_occ) max_occ = ren_cyc.size() - hs_cyc.size();
            if (valid_o) valid_cyc.push_back(rel_m);
            if (valid_o && data_ready_i) begin
                hs_cyc.push_back(rel_m);
                hs_data.push_back(data_o);
                hs_last.push_back(last_o);
            end
            if (done_o) done_cyc.push_back(rel_m);
            check_val("oreg_en_follows_ren", oreg_en_o, prev_ren);
        end
        prev_ren = ren_o;
    end

    task automatic clear_logs();
        ren_cyc.delete(); ren_addr.delete(); hs_cyc.delete(); hs_data.delete();
        hs_last.delete(); done_cyc.delete(); valid_cyc.delete();
        max_occ = 0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low in cycles 3..12
    function automatic logic rdy_for(input int mode, input int rel);
        if (mode == 1) return ($urandom_range(0, 9) < 7);
        if (mode == 2) return !(rel >= 3 && rel <= 12);
        return 1'b1;
    endfunction

    task automatic chk_reset_vals();
        check_val("rst_ready", ready_o, 1);
        check_val("rst_ren", ren_o, 0);
        check_val("rst_oreg_en", oreg_en_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_last", last_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_raddr", raddr_o, 0);
        check_val("rst_data", data_o, 0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1.
    task automatic run_req(input logic [AW-1:0] base, input int len, input int mode, input int abort_at);
        int rel, limit, rdy_rel, n_after;
        logic [AW-1:0] ea;
        clear_logs();
        start_i      = 1'b1;
        base_addr_i  = base;
        len_i        = CNT_W'(len);
        abort_i      = 1'b0;
        data_ready_i = rdy_for(mode, 0);
        t0 = cyc;
        logging = 1'b1;
        rel = 0;
        rdy_rel = -1;
        limit = 40 + 12 * len;
        while (rdy_rel < 0 && rel < limit) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            start_i      = 1'b0;
            abort_i      = (rel == abort_at);
            data_ready_i = rdy_for(mode, rel);
            if (ready_o) rdy_rel = rel;
        end
        if (rdy_rel < 0) check_val("timeout_ready", 0, 1);
        abort_i = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        logging = 1'b0;

        if (abort_at < 0) begin
            check_val("n_issue", ren_cyc.size(), len);
            check_val("n_deliv", hs_cyc.size(), len);
            check_val("n_done", done_cyc.size(), 1);
            for (int k = 0; k < ren_cyc.size() && k < len; k++) begin
                ea = AW'(int'(base) + k);
                check_val("issue_addr", ren_addr[k], ea);
            end
            for (int k = 0; k < hs_cyc.size() && k < len; k++) begin
                ea = AW'(int'(base) + k);
                check_val("elem_data", hs_data[k], vrf_word(ea));
                check_val("elem_last", hs_last[k], (k == len - 1));
            end
            check_val("occ_bound", (max_occ <= BUF_DEPTH), 1);
            if (len == 0) begin
                if (done_cyc.size() > 0) check_val("zero_done_cyc", done_cyc[0], 1);
                check_val("zero_ready", rdy_rel, 1);
            end else if (done_cyc.size() > 0) begin
                check_val("ready_at_done", rdy_rel, done_cyc[0]);
                if (hs_cyc.size() > 0) check_val("done_after_last", done_cyc[0], hs_cyc[hs_cyc.size()-1] + 1);
                if (mode == 0) check_val("done_latency", done_cyc[0], len + RD_LATENCY + 2);
            end
            if (mode == 0) begin
                for (int k = 0; k < ren_cyc.size() && k < len; k++)
                    check_val("issue_cycle", ren_cyc[k], 1 + k);
                for (int k = 0; k < hs_cyc.size() && k < len; k++)
                    check_val("deliver_cycle", hs_cyc[k], 2 + RD_LATENCY + k);
            end
        end else begin
            check_val("abort_no_done", done_cyc.size(), 0);
            check_val("abort_ready_cycle", rdy_rel, abort_at + RD_LATENCY + 1);
            n_after = 0;
            foreach (valid_cyc[i]) if (valid_cyc[i] > abort_at) n_after++;
            check_val("abort_no_valid_after", n_after, 0);
            n_after = 0;
            foreach (ren_cyc[i]) if (ren_cyc[i] > abort_at) n_after++;
            check_val("abort_no_ren_after", n_after, 0);
            for (int k = 0; k < hs_cyc.size(); k++) begin
                ea = AW'(int'(base) + k);
                check_val("abort_prefix_data", hs_data[k], vrf_word(ea));
                check_val("abort_prefix_last", hs_last[k], (k == len - 1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first;
        logic [AW-1:0] rb;
        int rl, ra, rm;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Basic request
        run_req(9'h010, 4, 0, -1);

        // Address wrap at the top of the VRF
        run_req(9'h1FE, 4, 0, -1);
        if (ren_addr.size() >= 4) begin
            check_val("wrap_addr2", ren_addr[2], 9'h000);
            check_val("wrap_addr3", ren_addr[3], 9'h001);
        end else check_val("wrap_issue_cnt", ren_addr.size(), 4);

        // Backpressure: consumer stalls for cycles 3..12
        run_req(9'h080, 16, 2, -1);
        n = 0;
        foreach (ren_cyc[i]) if (ren_cyc[i] <= 12) n++;
        check_val("bp_issue_stop", n, BUF_DEPTH);
        first = -1;
        foreach (ren_cyc[i]) if (ren_cyc[i] > 4 && first < 0) first = ren_cyc[i];
        check_val("bp_resume_cycle", first, 14);
        check_val("bp_max_outstanding", max_occ, BUF_DEPTH);
        if (hs_cyc.size() > 0) check_val("bp_first_hs", hs_cyc[0], 13);

        // Zero-length request
        run_req(9'h100, 0, 0, -1);

        // Abort in cycle 3, then a fresh request
        run_req(9'h0F0, 10, 0, 3);
        run_req(9'h020, 2, 0, -1);

        // Asynchronous reset in the middle of ISSUE
        start_i = 1'b1; base_addr_i = 9'h040; len_i = CNT_W'(8); data_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        @(posedge clk); @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        t0 = cyc;
        logging = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        logging = 1'b0;
        check_val("post_rst_no_ren", ren_cyc.size(), 0);
        check_val("post_rst_no_valid", valid_cyc.size(), 0);
        check_val("post_rst_ready", ready_o, 1);
        run_req(9'h055, 3, 0, -1);

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            rb = AW'($urandom_range(0, MEM_DEPTH - 1));
            rl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            ra = (rl > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, rl)) : -1;
            rm = ($urandom_range(0, 3) == 0) ? 0 : 1;
            run_req(rb, rl, rm, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
